// File: rtl/subservient_ram_wide.sv
// -----------------------------------------------------------------------------
// subservient_ram_wide
//
// Single-clock simple-dual-port RAM with one write port and one read port.
// Words are dw bits wide and dw must be a multiple of 8. Each byte has its own
// write enable. The design supports:
//   - selectable same-address read-during-write behaviour (old or new data),
//   - a read latency of 1 or 2 cycles, qualified by o_rvalid,
//   - an optional clear sequence after reset that writes zero to every word.
//
// Ports:
//   i_clk     clock, all logic on the rising edge
//   i_rst_n   synchronous active-low reset
//   i_waddr   write word address
//   i_wdata   write data
//   i_wmask   byte write enables, bit k covers bits [8k+7:8k]
//   i_wen     write strobe
//   i_raddr   read word address
//   i_ren     read strobe
//   o_rdata   read data; holds its last value when no result is delivered
//   o_rvalid  o_rdata carries the result of a read issued rd_latency cycles ago
//   o_ready   high once the RAM accepts accesses (after any clear sequence)
// -----------------------------------------------------------------------------
module subservient_ram_wide #(
  parameter int    dw           = 8,
  parameter int    depth        = 256,
  parameter int    aw           = $clog2(depth),
  parameter string memfile      = "",
  parameter int    rdw_mode     = 0,
  parameter int    rd_latency   = 1,
  parameter int    clear_on_rst = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_waddr,
  input  logic [dw-1:0] i_wdata,
  input  logic [dw/8-1:0] i_wmask,
  input  logic          i_wen,
  input  logic [aw-1:0] i_raddr,
  input  logic          i_ren,
  output logic [dw-1:0] o_rdata,
  output logic          o_rvalid,
  output logic          o_ready
);

  localparam int nb = dw / 8;

  // One extra bit so the bound compare also works when depth is a power of two.
  localparam logic [aw:0]   depth_w   = (aw + 1)'(depth);
  localparam logic [aw-1:0] last_addr = aw'(depth - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam state_e reset_state = (clear_on_rst != 0) ? CLEAR : READY;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (dw % 8 != 0) begin : g_bad_dw
    $error("subservient_ram_wide: dw (%0d) must be a multiple of 8", dw);
  end
  if (rd_latency != 1 && rd_latency != 2) begin : g_bad_latency
    $error("subservient_ram_wide: rd_latency (%0d) must be 1 or 2", rd_latency);
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [dw-1:0] mem [depth];

  // ---------------------------------------------------------------------------
  // CLEAR / READY state machine
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [aw-1:0] clr_cnt_q, clr_cnt_d;

  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= reset_state;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == last_addr) begin
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  logic ready;
  logic waddr_ok, raddr_ok;
  logic wr_accept, rd_accept;

  assign ready     = (state_q == READY);
  assign o_ready   = ready;
  assign waddr_ok  = ({1'b0, i_waddr} < depth_w);
  assign raddr_ok  = ({1'b0, i_raddr} < depth_w);
  assign wr_accept = ready && i_rst_n && i_wen;
  assign rd_accept = ready && i_rst_n && i_ren;

  // ---------------------------------------------------------------------------
  // Write port: the clear sequence owns the port while in CLEAR
  // ---------------------------------------------------------------------------
  logic          mem_we;
  logic [aw-1:0] mem_waddr;
  logic [dw-1:0] mem_wdata;
  logic [nb-1:0] mem_be;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_waddr;
    mem_wdata = i_wdata;
    mem_be    = i_wmask;
    if (state_q == CLEAR) begin
      mem_we    = i_rst_n;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_accept && waddr_ok) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the memory array has no reset; reset leaves contents untouched and
  // a resettable array would not map onto RAM macros.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < nb; k++) begin
        if (mem_be[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read word, including same-address forwarding in write-first mode
  // ---------------------------------------------------------------------------
  logic [dw-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      rd_word = mem[i_raddr];
      // Read-first needs nothing extra: the array still holds the old word.
      if (rdw_mode == 1 && wr_accept && i_waddr == i_raddr) begin
        for (int k = 0; k < nb; k++) begin
          if (i_wmask[k]) rd_word[8*k +: 8] = i_wdata[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline; data registers only load on a valid result so o_rdata holds
  // ---------------------------------------------------------------------------
  logic          rvalid1_q;
  logic [dw-1:0] rdata1_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rvalid1_q <= 1'b0;
      rdata1_q  <= '0;
    end else begin
      rvalid1_q <= rd_accept;
      if (rd_accept) rdata1_q <= rd_word;
    end
  end

  if (rd_latency == 2) begin : g_lat2
    logic          rvalid2_q;
    logic [dw-1:0] rdata2_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid1_q;
        if (rvalid1_q) rdata2_q <= rdata1_q;
      end
    end

    assign o_rvalid = rvalid2_q;
    assign o_rdata  = rdata2_q;
  end else begin : g_lat1
    assign o_rvalid = rvalid1_q;
    assign o_rdata  = rdata1_q;
  end

endmodule
